hpc3_logic_vec: RTL and testbench

- WIDTH-bit, d-th order masked two-input logic unit built from per-bit HPC3 AND gadgets.
- Per-transaction operation select: AND, OR, NAND or XOR. OR and NAND are derived by inverting share 0 only.
- Adds a valid/ready pipeline with backpressure and a randomness handshake; the bare single-bit gadgets have neither.
- Sits between masked datapath stages (S-box layers, masked comparators) that need streaming, stallable nonlinear operations.

---
 rtl/hpc3_logic_vec_if.sv | 41 ++++
 rtl/hpc3_logic_vec.sv | 162 ++++++++++++++++
 tb/tb_hpc3_logic_vec.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hpc3_logic_vec_if.sv
// Streaming bus for hpc3_logic_vec: operand/op input handshake, randomness
// handshake and result handshake.
//
// Signals:
//   in_valid/in_ready    operand handshake for a, b, op
//   op                   00 AND, 01 OR, 10 NAND, 11 XOR
//   a, b                 shared operands, share-major (share s of lane i at s*WIDTH+i)
//   rnd                  fresh randomness, lane i uses [i*d*(d+1) +: d*(d+1)]
//   rnd_valid/rnd_ready  randomness handshake
//   out_valid/out_ready  result handshake
//   c                    shared result, same packing as a
// Modports: master = producer/consumer side (testbench), slave = the unit.
interface hpc3_logic_vec_if #(
    parameter int unsigned security_order = 1,
    parameter int unsigned WIDTH          = 8
);
    localparam int unsigned SW   = (security_order + 1) * WIDTH;
    localparam int unsigned RNDW = WIDTH * security_order * (security_order + 1);

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [SW-1:0]   a;
    logic [SW-1:0]   b;
    logic [RNDW-1:0] rnd;
    logic            rnd_valid;
    logic            rnd_ready;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   c;

    modport master (
        output in_valid, op, a, b, rnd, rnd_valid, out_ready,
        input  in_ready, rnd_ready, out_valid, c
    );

    modport slave (
        input  in_valid, op, a, b, rnd, rnd_valid, out_ready,
        output in_ready, rnd_ready, out_valid, c
    );
endinterface

// File: rtl/hpc3_logic_vec.sv
// WIDTH-lane, d-th order masked two-input logic unit (AND/OR/NAND/XOR) built from
// per-bit HPC3 AND gadgets, with valid/ready backpressure and a randomness handshake.
// Latency is 1 + pipeline cycles for every op.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  hpc3_logic_vec_if.slave: in_valid/in_ready, op, a, b, rnd, rnd_valid/rnd_ready,
//        out_valid/out_ready, c
//
// Build option: define HPC3_ZEROIZE_EN to flush share registers with zeros whenever a
// stage advances without a valid transaction, so c reads 0 while out_valid is 0.
module hpc3_logic_vec #(
    parameter int unsigned security_order = 1,
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned pipeline       = 1
) (
    input logic            clk,
    input logic            rst,
    hpc3_logic_vec_if.slave bus
);
    localparam int unsigned NS = security_order + 1;       // shares per bit
    localparam int unsigned NP = security_order * NS / 2;  // unordered share pairs
    localparam int unsigned RW = security_order * NS;      // random bits per lane
    localparam int unsigned SW = NS * WIDTH;

    typedef enum logic [1:0] {OpAnd = 2'b00, OpOr = 2'b01, OpNand = 2'b10, OpXor = 2'b11} op_e;

    // Index of unordered pair (lo, hi), lo < hi, in 0..NP-1.
    function automatic int unsigned pair_idx(input int unsigned lo, input int unsigned hi);
        return lo * (2 * NS - lo - 1) / 2 + (hi - lo - 1);
    endfunction

    logic                             w_stall;
    logic                             w_in_ready;
    logic                             w_accept;
    logic                             w_inv;
    logic [NS-1:0]                    w_a;
    logic [NS-1:0]                    w_b;
    logic                             w_r;
    logic                             w_rq;
    int unsigned                      w_idx;
    logic                             r_v0;
    logic [1:0]                       r_op0;
    logic [1:0]                       w_op_d;
    logic [SW-1:0]                    r_xor;
    logic [SW-1:0]                    w_xor_d;
    // [lane][i][j]: p holds a_i & (b_j ^ r_ij) (diagonal: a_i & b_i), q holds ~a_i & r_ij ^ r'_ij
    logic [WIDTH-1:0][NS-1:0][NS-1:0] r_p;
    logic [WIDTH-1:0][NS-1:0][NS-1:0] r_q;
    logic [WIDTH-1:0][NS-1:0][NS-1:0] w_p_d;
    logic [WIDTH-1:0][NS-1:0][NS-1:0] w_q_d;
    logic [SW-1:0]                    w_s0_c;

    // in_ready never looks at in_valid, only at the output side and randomness.
    assign w_stall       = bus.out_valid & ~bus.out_ready;
    assign w_in_ready    = ~rst & ~w_stall & bus.rnd_valid;
    assign w_accept      = bus.in_valid & w_in_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.rnd_ready = w_accept;

    // Gadget first half: input products, blinded with the shared randomness.
    always_comb begin
        w_p_d   = '0;
        w_q_d   = '0;
        w_a     = '0;
        w_b     = '0;
        w_r     = 1'b0;
        w_rq    = 1'b0;
        w_idx   = 0;
        // OR = ~AND(~a, ~b); inverting share 0 inverts the unmasked value.
        w_inv   = (op_e'(bus.op) == OpOr);
        w_op_d  = bus.op;
        w_xor_d = bus.a ^ bus.b;
        for (int unsigned l = 0; l < WIDTH; l++) begin
            for (int unsigned s = 0; s < NS; s++) begin
                w_a[s] = bus.a[s * WIDTH + l];
                w_b[s] = bus.b[s * WIDTH + l];
            end
            w_a[0] = w_a[0] ^ w_inv;
            w_b[0] = w_b[0] ^ w_inv;
            for (int unsigned i = 0; i < NS; i++) begin
                for (int unsigned j = 0; j < NS; j++) begin
                    if (i == j) begin
                        w_p_d[l][i][j] = w_a[i] & w_b[i];
                    end else begin
                        // r_ij = r_ji and r'_ij = r'_ji so both cancel in the share sum.
                        w_idx          = (i < j) ? pair_idx(i, j) : pair_idx(j, i);
                        w_r            = bus.rnd[l * RW + w_idx];
                        w_rq           = bus.rnd[l * RW + NP + w_idx];
                        w_p_d[l][i][j] = w_a[i] & (w_b[j] ^ w_r);
                        w_q_d[l][i][j] = (~w_a[i] & w_r) ^ w_rq;
                    end
                end
            end
        end
`ifdef HPC3_ZEROIZE_EN
        if (!w_accept) begin
            w_p_d   = '0;
            w_q_d   = '0;
            w_xor_d = '0;
            w_op_d  = '0;
        end
`endif
    end

    // Stage 0 registers (the gadget registers) share the stall enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0  <= 1'b0;
            r_op0 <= '0;
            r_xor <= '0;
            r_p   <= '0;
            r_q   <= '0;
        end else if (!w_stall) begin
            r_v0  <= w_accept;
            r_op0 <= w_op_d;
            r_xor <= w_xor_d;
            r_p   <= w_p_d;
            r_q   <= w_q_d;
        end
    end

    // Gadget second half: share compression, then registered-op output mapping.
    always_comb begin
        w_s0_c = '0;
        for (int unsigned l = 0; l < WIDTH; l++) begin
            for (int unsigned i = 0; i < NS; i++) begin
                for (int unsigned j = 0; j < NS; j++) begin
                    w_s0_c[i * WIDTH + l] = w_s0_c[i * WIDTH + l] ^ r_p[l][i][j] ^ r_q[l][i][j];
                end
            end
        end
        unique case (op_e'(r_op0))
            OpXor:        w_s0_c = r_xor;
            OpOr, OpNand: w_s0_c[WIDTH-1:0] = ~w_s0_c[WIDTH-1:0];
            default:      ;
        endcase
    end

    if (pipeline != 0) begin : g_pipe
        logic          r_v1;
        logic [SW-1:0] r_c1;

        // A zeroized stage 0 already presents all-zero shares, so no extra gating here.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v1 <= 1'b0;
                r_c1 <= '0;
            end else if (!w_stall) begin
                r_v1 <= r_v0;
                r_c1 <= w_s0_c;
            end
        end

        assign bus.out_valid = r_v1;
        assign bus.c         = r_c1;
    end else begin : g_nopipe
        assign bus.out_valid = r_v0;
        assign bus.c         = w_s0_c;
    end
endmodule

// File: tb/tb_hpc3_logic_vec.sv
// Self-checking bench for hpc3_logic_vec (d=1, WIDTH=4, pipeline=1): directed latency,
// streaming, stall, randomness-blocking and reset steps followed by a random stream,
// checked against an unmasked reference model and an in-order scoreboard.
module tb_hpc3_logic_vec;
    localparam int unsigned D  = 1;
    localparam int unsigned W  = 4;
    localparam int unsigned P  = 1;
    localparam int unsigned NS = D + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hpc3_logic_vec_if #(.security_order(D), .WIDTH(W)) bus ();

    hpc3_logic_vec #(.security_order(D), .WIDTH(W), .pipeline(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned       n_checks = 0;
    int unsigned       n_errors = 0;
    int unsigned       n_out    = 0;
    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      cur_exp;
    logic              was_stall = 1'b0;
    logic [NS*W-1:0]   held_c;
    logic [NS*W-1:0]   save_c;
    int unsigned       n_base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        case (op)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return ~(x & y);
            default: return x ^ y;
        endcase
    endfunction

    function automatic logic [NS*W-1:0] mask(input logic [W-1:0] x);
        logic [NS*W-1:0] v;
        logic [W-1:0]    acc;
        acc = x;
        v   = '0;
        for (int s = 1; s < int'(NS); s++) begin
            v[s*W +: W] = W'($urandom);
            acc         = acc ^ v[s*W +: W];
        end
        v[W-1:0] = acc;
        return v;
    endfunction

    function automatic logic [W-1:0] unmask(input logic [NS*W-1:0] v);
        logic [W-1:0] acc;
        acc = '0;
        for (int s = 0; s < int'(NS); s++) acc = acc ^ v[s*W +: W];
        return acc;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        bus.op       = op;
        bus.a        = mask(x);
        bus.b        = mask(y);
        bus.rnd      = $bits(bus.rnd)'($urandom);
        bus.in_valid = 1'b1;
        cur_exp      = ref_op(op, x, y);
        #1;
    endtask

    // One clock: protocol checks, scoreboard bookkeeping, then advance to negedge + 1.
    task automatic tick();
        logic exp_rdy;
        logic accepted;
        accepted = 1'b0;
        exp_rdy  = !rst && !(bus.out_valid && !bus.out_ready) && bus.rnd_valid;
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("rnd_ready", bus.rnd_ready, bus.in_valid && exp_rdy);
        if (was_stall) begin
            chk("held_c", bus.c, held_c);
            chk("held_valid", bus.out_valid, 1);
        end
`ifdef HPC3_ZEROIZE_EN
        if (!bus.out_valid) chk("zero_c", bus.c, 0);
`endif
        if (bus.in_valid && bus.in_ready && !rst) begin
            exp_q.push_back(cur_exp);
            accepted = 1'b1;
        end
        if (bus.out_valid && bus.out_ready && !rst) begin
            chk("queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("result", unmask(bus.c), exp_q.pop_front());
            n_out++;
        end
        was_stall = bus.out_valid && !bus.out_ready && !rst;
        held_c    = bus.c;
        @(posedge clk);
        @(negedge clk);
        if (accepted) bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.in_valid); i++) tick();
        chk("drained", exp_q.size(), 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.rnd       = '0;
        bus.rnd_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        tick();
        tick();
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_c", bus.c, 0);
        rst = 1'b0;
        #1;

        // AND 0xC & 0xA, latency 2.
        drive(2'd0, 4'hC, 4'hA);
        chk("and_accept", bus.rnd_ready, 1);
        tick();
        chk("lat_ov_1", bus.out_valid, 0);
        tick();
        chk("lat_ov_2", bus.out_valid, 1);
        chk("and_value", unmask(bus.c), 4'h8);
        tick();
        chk("and_ov_after", bus.out_valid, 0);

        // Back-to-back OR, NAND, XOR on 0x5, 0x3.
        drive(2'd1, 4'h5, 4'h3);
        tick();
        drive(2'd2, 4'h5, 4'h3);
        tick();
        chk("or_valid", bus.out_valid, 1);
        chk("or_value", unmask(bus.c), 4'h7);
        drive(2'd3, 4'h5, 4'h3);
        tick();
        chk("nand_valid", bus.out_valid, 1);
        chk("nand_value", unmask(bus.c), 4'hE);
        tick();
        chk("xor_valid", bus.out_valid, 1);
        chk("xor_value", unmask(bus.c), 4'h6);
        tick();
        chk("stream_idle", bus.out_valid, 0);

        // Stall with a full pipeline for 5 cycles.
        n_base        = n_out;
        bus.out_ready = 1'b0;
        #1;
        drive(2'($urandom), W'($urandom), W'($urandom));
        tick();
        drive(2'($urandom), W'($urandom), W'($urandom));
        tick();
        drive(2'($urandom), W'($urandom), W'($urandom));
        save_c = bus.c;
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_rnd_ready", bus.rnd_ready, 0);
            chk("stall_c", bus.c, save_c);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        drain();
        chk("stall_count", n_out - n_base, 3);

        // Randomness not available blocks acceptance.
        bus.rnd_valid = 1'b0;
        #1;
        drive(2'd0, 4'hF, 4'h9);
        for (int i = 0; i < 3; i++) begin
            chk("norand_in_ready", bus.in_ready, 0);
            chk("norand_rnd_ready", bus.rnd_ready, 0);
            tick();
        end
        bus.rnd_valid = 1'b1;
        #1;
        chk("rand_back_rnd_ready", bus.rnd_ready, 1);
        tick();
        drain();

        // Reset with two transactions in flight.
        n_base = n_out;
        drive(2'd1, 4'h1, 4'h2);
        tick();
        drive(2'd2, 4'h3, 4'h4);
        tick();
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        #1;
        tick();
        chk("rst_flight_ov", bus.out_valid, 0);
        chk("rst_flight_c", bus.c, 0);
        exp_q.delete();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("rst_no_output", bus.out_valid, 0);
            tick();
        end
        chk("rst_discard_count", n_out - n_base, 0);

        // Random stream with random backpressure and randomness gaps.
        for (int i = 0; i < 400; i++) begin
            if (!bus.in_valid && ($urandom % 4 != 0))
                drive(2'($urandom), W'($urandom), W'($urandom));
            bus.rnd_valid = ($urandom % 4 != 0);
            bus.out_ready = ($urandom % 3 != 0);
            #1;
            tick();
        end
        bus.rnd_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
